// File: rtl/cv_bus_term_pipe.sv
// Bus-reducing gate cell with valid/ready handshakes and a 2-entry output buffer.
// Adds a saturating toggle counter on popped results and a sticky reserved-mode flag.
module cv_bus_term_pipe #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             VDD,
  input  logic             VSS,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] tog_cnt,
  output logic             mode_err,
  input  logic             cnt_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e occ_q, occ_d;
  logic h0_q, h0_d;
  logic h1_q, h1_d;
  logic last_q;
  logic res;
  logic push, pop, tog;
  logic unused_supply;

  // Supply pins exist only so the cell drops into existing netlists.
  assign unused_supply = VDD ^ VSS;

  assign in_ready  = (occ_q != FULL);
  assign out_valid = (occ_q != EMPTY);
  assign out       = h0_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign tog       = pop & (out != last_q);

  always_comb begin
    res = 1'b0;
    case (mode)
      3'd0:    res = ~(|in);
      3'd1:    res = ~(&in);
      3'd2:    res = |in;
      3'd3:    res = &in;
      3'd4:    res = ^in;
      3'd5:    res = ~(^in);
      default: res = 1'b0;
    endcase
  end

  // Head lives in h0 so out is a plain register; h0 is zeroed when the buffer empties.
  always_comb begin
    occ_d = occ_q;
    h0_d  = h0_q;
    h1_d  = h1_q;
    case (occ_q)
      EMPTY: begin
        if (push) begin
          occ_d = ONE;
          h0_d  = res;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            occ_d = FULL;
            h1_d  = res;
          end
          2'b01: begin
            occ_d = EMPTY;
            h0_d  = 1'b0;
          end
          2'b11:   h0_d = res;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          occ_d = ONE;
          h0_d  = h1_q;
        end
      end
      default: begin
        occ_d = EMPTY;
        h0_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      occ_q    <= EMPTY;
      h0_q     <= 1'b0;
      h1_q     <= 1'b0;
      last_q   <= 1'b0;
      tog_cnt  <= '0;
      mode_err <= 1'b0;
    end else begin
      occ_q <= occ_d;
      h0_q  <= h0_d;
      h1_q  <= h1_d;
      if (tog) last_q <= out;
      if (cnt_clr) begin
        tog_cnt  <= '0;
        mode_err <= 1'b0;
      end else begin
        if (tog && (tog_cnt != '1)) tog_cnt <= tog_cnt + CNT_W'(1);
        if (push && (mode[2:1] == 2'b11)) mode_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv_bus_term_pipe.sv
// Scoreboard bench for cv_bus_term_pipe: an 8-bit/8-bit-counter instance and a
// 1-bit/2-bit-counter instance share one stimulus stream.
module tb_cv_bus_term_pipe;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       vdd = 1'b1;
  logic       vss = 1'b0;
  logic [7:0] din = '0;
  logic [2:0] mode = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       in_ready, out, out_valid, mode_err;
  logic [7:0] tog_cnt;
  logic       in_ready1, out1, out_valid1, mode_err1;
  logic [1:0] tog_cnt1;

  int unsigned vecs = 0;
  int unsigned errs = 0;
  logic sbq0[$];
  logic sbq1[$];

  always #5 clk = ~clk;

  cv_bus_term_pipe #(.WIDTH(8), .CNT_W(8)) dut0 (
    .clk(clk), .rstb(rstb), .VDD(vdd), .VSS(vss),
    .in(din), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .tog_cnt(tog_cnt), .mode_err(mode_err), .cnt_clr(cnt_clr)
  );

  cv_bus_term_pipe #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rstb(rstb), .VDD(vdd), .VSS(vss),
    .in(din[0:0]), .mode(mode), .in_valid(in_valid), .in_ready(in_ready1),
    .out(out1), .out_valid(out_valid1), .out_ready(out_ready),
    .tog_cnt(tog_cnt1), .mode_err(mode_err1), .cnt_clr(cnt_clr)
  );

  function automatic logic f(input logic [7:0] d, input int unsigned w, input logic [2:0] m);
    logic a, o, x;
    a = 1'b1; o = 1'b0; x = 1'b0;
    for (int unsigned i = 0; i < w; i++) begin
      a &= d[i];
      o |= d[i];
      x ^= d[i];
    end
    case (m)
      3'd0:    return ~o;
      3'd1:    return ~a;
      3'd2:    return o;
      3'd3:    return a;
      3'd4:    return x;
      3'd5:    return ~x;
      default: return 1'b0;
    endcase
  endfunction

  // Called at a falling edge; drives one cycle, samples handshake, returns at the next falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] m,
                      input logic rdy, input logic clr,
                      output logic pushed, output logic popped,
                      output logic g0, output logic g1);
    in_valid = v; din = d; mode = m; out_ready = rdy; cnt_clr = clr;
    #1;
    pushed = in_valid & in_ready;
    popped = out_valid & out_ready;
    g0 = out;
    g1 = out1;
    if (pushed) begin
      sbq0.push_back(f(d, 8, m));
      sbq1.push_back(f(d, 1, m));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    rstb = 1'b0;
    sbq0.delete();
    sbq1.delete();
    repeat (2) @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if ({in_ready, out_valid, out, mode_err, tog_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      $display("FAIL reset_dut0: got %b want %b", {in_ready, out_valid, out, mode_err, tog_cnt}, 12'b1000_0000_0000);
      errs++;
    end
    vecs++;
    if ({in_ready1, out_valid1, out1, mode_err1, tog_cnt1} !== 6'b100000) begin
      $display("FAIL reset_dut1: got %b want %b", {in_ready1, out_valid1, out1, mode_err1, tog_cnt1}, 6'b100000);
      errs++;
    end
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_reduce(input string nm, input logic [2:0] m, input logic [31:0] pats,
                             input logic [7:0] exp_tog);
    logic p, q, g0, g1, e;
    int pops = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(i < 4, (i < 4) ? pats[8*i +: 8] : 8'h00, m, 1'b1, 1'b0, p, q, g0, g1);
      if (i >= 1 && i <= 4) begin
        vecs++;
        if (q !== 1'b1) begin
          $display("FAIL %s_latency cycle %0d: out_valid %b want 1", nm, i, q);
          errs++;
        end
      end
      if (q) begin
        e = (sbq0.size() != 0) ? sbq0.pop_front() : 1'bx;
        vecs++;
        if (g0 !== e) begin
          $display("FAIL %s_out pop %0d: got %b want %b", nm, pops, g0, e);
          errs++;
        end
        pops++;
      end
    end
    vecs++;
    if (tog_cnt !== exp_tog) begin
      $display("FAIL %s_tog: got %0d want %0d", nm, tog_cnt, exp_tog);
      errs++;
    end
  endtask

  task automatic test_back_to_back();
    logic p, q, g0, g1, e;
    logic want_p [3];
    int pops = 0;
    logic cdone = 1'b0;
    want_p[0] = 1'b1; want_p[1] = 1'b1; want_p[2] = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 1) ? 8'h01 : 8'hFF, 3'(i + 1), 1'b0, 1'b0, p, q, g0, g1);
      vecs++;
      if (p !== want_p[i]) begin
        $display("FAIL b2b_accept push %0d: got %b want %b", i, p, want_p[i]);
        errs++;
      end
    end
    step(1'b1, 8'hFF, 3'd3, 1'b0, 1'b0, p, q, g0, g1);
    vecs++;
    if (sbq0.size() == 0 || g0 !== sbq0[0] || out_valid !== 1'b1) begin
      $display("FAIL b2b_hold: out %b valid %b want head %b valid 1", g0, out_valid,
               (sbq0.size() != 0) ? sbq0[0] : 1'bx);
      errs++;
    end
    for (int i = 0; i < 8; i++) begin
      step(!cdone, 8'hFF, 3'd3, 1'b1, 1'b0, p, q, g0, g1);
      if (p) cdone = 1'b1;
      if (q) begin
        e = (sbq0.size() != 0) ? sbq0.pop_front() : 1'bx;
        vecs++;
        if (g0 !== e) begin
          $display("FAIL b2b_out pop %0d: got %b want %b", pops, g0, e);
          errs++;
        end
        pops++;
      end
    end
    vecs++;
    if (pops != 3 || !cdone || sbq0.size() != 0) begin
      $display("FAIL b2b_count: pops %0d third_accepted %b left %0d want 3 1 0", pops, cdone, sbq0.size());
      errs++;
    end
  endtask

  task automatic test_mode_err();
    logic p, q, g0, g1, e;
    do_reset();
    step(1'b1, 8'hFF, 3'd6, 1'b1, 1'b0, p, q, g0, g1);
    vecs++;
    if (mode_err !== 1'b1) begin
      $display("FAIL merr_set: got %b want 1", mode_err);
      errs++;
    end
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, p, q, g0, g1);
        1:       step(1'b1, 8'h01, 3'd2, 1'b1, 1'b0, p, q, g0, g1);
        2:       step(1'b1, 8'hFF, 3'd7, 1'b1, 1'b1, p, q, g0, g1);
        default: step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, p, q, g0, g1);
      endcase
      if (q) begin
        e = (sbq0.size() != 0) ? sbq0.pop_front() : 1'bx;
        vecs++;
        if (g0 !== e) begin
          $display("FAIL merr_out step %0d: got %b want %b", i, g0, e);
          errs++;
        end
      end
      if (i == 2) begin
        vecs++;
        if ({tog_cnt, mode_err} !== 9'h000) begin
          $display("FAIL clr_priority: tog %0d err %b want 0 0", tog_cnt, mode_err);
          errs++;
        end
      end
    end
    vecs++;
    if ({tog_cnt, mode_err} !== {8'd1, 1'b0}) begin
      $display("FAIL clr_keeps_last: tog %0d err %b want 1 0", tog_cnt, mode_err);
      errs++;
    end
  endtask

  task automatic test_saturate();
    logic p, q, g0, g1, e;
    int pops = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(i < 8, (i % 2 == 0) ? 8'h01 : 8'h00, 3'd2, 1'b1, 1'b0, p, q, g0, g1);
      if (q) begin
        e = (sbq1.size() != 0) ? sbq1.pop_front() : 1'bx;
        vecs++;
        if (g1 !== e) begin
          $display("FAIL sat_out pop %0d: got %b want %b", pops, g1, e);
          errs++;
        end
        pops++;
      end
    end
    vecs++;
    if (tog_cnt1 !== 2'd3 || pops != 8) begin
      $display("FAIL sat_tog: got %0d pops %0d want 3 pops 8", tog_cnt1, pops);
      errs++;
    end
    for (int k = 0; k < 13; k++) begin
      step(k < 12, (k % 2 == 1) ? 8'h01 : 8'h00, 3'(k / 2), 1'b1, 1'b0, p, q, g0, g1);
      if (q) begin
        e = (sbq1.size() != 0) ? sbq1.pop_front() : 1'bx;
        vecs++;
        if (g1 !== e) begin
          $display("FAIL w1_out mode %0d in %0d: got %b want %b", (k - 1) / 2, (k - 1) % 2, g1, e);
          errs++;
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic p, q, g0, g1, e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(i < 5, (i % 2 == 0) ? 8'h01 : 8'h00, 3'd2, 1'b1, 1'b0, p, q, g0, g1);
      if (q) begin
        e = (sbq0.size() != 0) ? sbq0.pop_front() : 1'bx;
        vecs++;
        if (g0 !== e) begin
          $display("FAIL mid_out cycle %0d: got %b want %b", i, g0, e);
          errs++;
        end
      end
    end
    step(1'b1, 8'h01, 3'd2, 1'b0, 1'b0, p, q, g0, g1);
    step(1'b1, 8'h00, 3'd2, 1'b0, 1'b0, p, q, g0, g1);
    vecs++;
    if ({tog_cnt, in_ready, out_valid} !== {8'd5, 1'b0, 1'b1}) begin
      $display("FAIL mid_prefill: tog %0d ready %b valid %b want 5 0 1", tog_cnt, in_ready, out_valid);
      errs++;
    end
    #2;
    rstb = 1'b0;
    #1;
    vecs++;
    if ({in_ready, out_valid, out, mode_err, tog_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      $display("FAIL mid_async: got %b want %b", {in_ready, out_valid, out, mode_err, tog_cnt}, 12'b1000_0000_0000);
      errs++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    sbq0.delete();
    sbq1.delete();
    @(negedge clk);
    rstb = 1'b1;
    step(1'b1, 8'hFF, 3'd1, 1'b1, 1'b0, p, q, g0, g1);
    step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, p, q, g0, g1);
    e = (q && sbq0.size() != 0) ? sbq0.pop_front() : 1'bx;
    vecs++;
    if (g0 !== e || e !== 1'b0) begin
      $display("FAIL mid_nand: got %b want 0", g0);
      errs++;
    end
    vecs++;
    if (tog_cnt !== 8'd0) begin
      $display("FAIL mid_tog: got %0d want 0", tog_cnt);
      errs++;
    end
  endtask

  initial begin
    test_reset();
    test_reduce("nor", 3'd0, 32'h03_02_01_00, 8'd2);
    test_reduce("xor", 3'd4, 32'h07_03_01_00, 8'd3);
    test_back_to_back();
    test_mode_err();
    test_saturate();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
